serial_adder: RTL and testbench

Parametrised multi-cycle adder that accepts two WIDTH-bit operands plus carry-in and adds them CHUNK bits per clock, LSB chunk first, using a registered carry between chunks. It is the sequential, width-generic successor to the team's single-bit adder cells. It sits between operand producers and consumers on valid/ready handshakes. It trades latency for a small CHUNK-bit datapath.

---
 rtl/adder_pkg.sv | 29 ++
 rtl/serial_adder_chunk_adder.sv | 44 ++++
 rtl/serial_adder.sv | 173 +++++++++++++++++
 tb/tb_serial_adder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_pkg
//  Description : Shared definitions for the chunked serial adder: FSM state
//                encoding and helpers that derive the step count and the
//                step-counter width from the operand and chunk widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

    // FSM state encoding, 2 bits wide
    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Number of chunk additions needed to cover the full operand width
    function automatic int calc_steps(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Step counter width; at least one bit even when a single step suffices
    function automatic int calc_cnt_w(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage : adder_pkg
`default_nettype wire

// File: rtl/serial_adder_chunk_adder.sv
`default_nettype none
// ============================================================================
//  Module      : chunk_adder
//  Description : Combinational CHUNK-bit ripple-carry adder built from
//                full-adder cells. Besides the sum and the carry-out it
//                exposes the carry into its top bit, which the parent needs
//                to derive signed overflow on the most significant chunk.
//  Revision    : 1.0 - initial release
// ============================================================================
module chunk_adder #(
    parameter int CHUNK = 1
) (
    input  logic [CHUNK-1:0] a_chunk,
    input  logic [CHUNK-1:0] b_chunk,
    input  logic             ci,
    output logic [CHUNK-1:0] s_chunk,
    output logic             co,
    output logic             c_msb
);

    // Carry chain: w_carry[i] is the carry into bit i, w_carry[CHUNK] the carry out
    logic [CHUNK:0] w_carry;

    assign w_carry[0] = ci;

    // One full-adder cell per bit of the chunk
    generate
        for (genvar i = 0; i < CHUNK; i++) begin : g_fa
            logic w_p;
            logic w_g;

            // Propagate / generate terms of this cell
            assign w_p            = a_chunk[i] ^ b_chunk[i];
            assign w_g            = a_chunk[i] & b_chunk[i];
            assign s_chunk[i]     = w_p ^ w_carry[i];
            assign w_carry[i + 1] = w_g | (w_p & w_carry[i]);
        end
    endgenerate

    assign co    = w_carry[CHUNK];
    assign c_msb = w_carry[CHUNK - 1];

endmodule : chunk_adder
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Multi-cycle adder. Accepts two WIDTH-bit operands and a
//                carry-in on a valid/ready handshake, adds them CHUNK bits
//                per clock (LSB chunk first) with a registered carry between
//                chunks, and presents sum, carry-out and signed overflow on
//                a second valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int STEPS = calc_steps(WIDTH, CHUNK);
    localparam int CNT_W = calc_cnt_w(STEPS);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("serial_adder: WIDTH must be at least 2");
        end
        if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
            $error("serial_adder: CHUNK must be positive and divide WIDTH");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             carry_q,  carry_d;
    logic             ovf_q,    ovf_d;

    // ------------------------------------------------------------------
    // Chunk datapath
    // ------------------------------------------------------------------
    logic [CHUNK-1:0]       w_s_chunk;
    logic                   w_co;
    logic                   w_c_msb;
    logic [WIDTH+CHUNK-1:0] w_sum_cat;
    logic [WIDTH-1:0]       w_sum_shift;
    logic                   w_last;

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a_chunk (a_sh_q[CHUNK-1:0]),
        .b_chunk (b_sh_q[CHUNK-1:0]),
        .ci      (carry_q),
        .s_chunk (w_s_chunk),
        .co      (w_co),
        .c_msb   (w_c_msb)
    );

    // New chunk enters the sum register from the MSB side; after STEPS
    // shifts the first (LSB) chunk has reached bit 0. Concatenating first
    // keeps this legal when CHUNK equals WIDTH.
    assign w_sum_cat   = {w_s_chunk, sum_q};
    assign w_sum_shift = w_sum_cat[WIDTH+CHUNK-1:CHUNK];
    assign w_last      = (cnt_q == LAST_STEP);

    // Next-state logic for the FSM, counter, shift registers and flags
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                // in_ready is high whenever the FSM is idle out of reset;
                // reset itself overrides everything in the flop block.
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                a_sh_d  = a_sh_q >> CHUNK;
                b_sh_d  = b_sh_q >> CHUNK;
                sum_d   = w_sum_shift;
                carry_d = w_co;
                cnt_d   = cnt_q + CNT_ONE;
                if (w_last) begin
                    // Top chunk: carry into the MSB versus carry out of it
                    ovf_d   = w_c_msb ^ w_co;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                // Result is held until the consumer takes it
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all registered except in_ready, which also masks on rst
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign sum       = sum_q;
    assign cout      = carry_q;
    assign ovf       = ovf_q;

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Directed self-checking bench for serial_adder. One instance
//                uses WIDTH=8/CHUNK=1, a second WIDTH=8/CHUNK=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // CHUNK=1 instance signals
    logic       in_valid  = 1'b0;
    logic       in_ready;
    logic [7:0] a         = 8'h00;
    logic [7:0] b         = 8'h00;
    logic       cin       = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       busy;

    // CHUNK=4 instance signals
    logic       in_valid4  = 1'b0;
    logic       in_ready4;
    logic [7:0] a4         = 8'h00;
    logic [7:0] b4         = 8'h00;
    logic       cin4       = 1'b0;
    logic       out_valid4;
    logic       out_ready4 = 1'b0;
    logic [7:0] sum4;
    logic       cout4;
    logic       ovf4;
    logic       busy4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .CHUNK(1)) u_dut1 (
        .clk (clk), .rst (rst),
        .in_valid (in_valid), .in_ready (in_ready),
        .a (a), .b (b), .cin (cin),
        .out_valid (out_valid), .out_ready (out_ready),
        .sum (sum), .cout (cout), .ovf (ovf), .busy (busy)
    );

    serial_adder #(.WIDTH(8), .CHUNK(4)) u_dut4 (
        .clk (clk), .rst (rst),
        .in_valid (in_valid4), .in_ready (in_ready4),
        .a (a4), .b (b4), .cin (cin4),
        .out_valid (out_valid4), .out_ready (out_ready4),
        .sum (sum4), .cout (cout4), .ovf (ovf4), .busy (busy4)
    );

    // Present one operand set for a single edge (call at a negedge)
    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        a        = ta;
        b        = tb;
        cin      = tc;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count negedges until out_valid, bounded
    task automatic wait_result(output int cycles);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, busy, cout, ovf} !== 5'b0 || sum !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b vld=%b busy=%b cout=%b ovf=%b sum=%h, want all 0",
                     in_ready, out_valid, busy, cout, ovf, sum);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b busy=%b, want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_basic();
        int cyc;
        start_op(8'h5A, 8'h3C, 1'b0);
        n_checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_run_flags: rdy=%b busy=%b vld=%b, want 0 1 0", in_ready, busy, out_valid);
        end
        wait_result(cyc);
        n_checks++;
        if (cyc !== 8) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles, want 8", cyc);
        end
        n_checks++;
        if (sum !== 8'h96 || cout !== 1'b0 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_result: sum=%h cout=%b ovf=%b, want 96 0 1", sum, cout, ovf);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_handshake: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_carry();
        int cyc;
        start_op(8'hFF, 8'h01, 1'b0);
        wait_result(cyc);
        n_checks++;
        if (cyc !== 8 || sum !== 8'h00 || cout !== 1'b1 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL carry_ff_01: cyc=%0d sum=%h cout=%b ovf=%b, want 8 00 1 0", cyc, sum, cout, ovf);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start_op(8'h80, 8'h80, 1'b1);
        wait_result(cyc);
        n_checks++;
        if (cyc !== 8 || sum !== 8'h01 || cout !== 1'b1 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL carry_80_80_c1: cyc=%0d sum=%h cout=%b ovf=%b, want 8 01 1 1", cyc, sum, cout, ovf);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int cyc;
        start_op(8'h5A, 8'h3C, 1'b0);
        wait_result(cyc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 8'h96 || cout !== 1'b0 || ovf !== 1'b1) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: vld=%b rdy=%b sum=%h cout=%b ovf=%b, want 1 0 96 0 1",
                         i, out_valid, in_ready, sum, cout, ovf);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_operand_change();
        int cyc;
        a        = 8'h5A;
        b        = 8'h3C;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        // Operands change after acceptance while in_valid stays asserted
        a = 8'h00;
        b = 8'h00;
        wait_result(cyc);
        n_checks++;
        if (cyc !== 8 || sum !== 8'h96 || cout !== 1'b0 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL operand_change: cyc=%0d sum=%h cout=%b ovf=%b, want 8 96 0 1", cyc, sum, cout, ovf);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 8'h96) begin
            n_fail++;
            $display("FAIL no_accept_while_busy: vld=%b rdy=%b sum=%h, want 1 0 96", out_valid, in_ready, sum);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_early_ready();
        int cyc;
        // out_ready high throughout the run must not shorten or skip DONE
        out_ready = 1'b1;
        start_op(8'h12, 8'h34, 1'b1);
        wait_result(cyc);
        n_checks++;
        if (cyc !== 8 || sum !== 8'h47 || cout !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL early_ready: cyc=%0d sum=%h cout=%b ovf=%b, want 8 47 0 0", cyc, sum, cout, ovf);
        end
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL early_ready_done: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_midrun();
        int cyc;
        start_op(8'h5A, 8'h3C, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || sum !== 8'h00 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midrun: vld=%b busy=%b sum=%h rdy=%b, want 0 0 00 0",
                     out_valid, busy, sum, in_ready);
        end
        rst = 1'b0;
        start_op(8'h01, 8'h02, 1'b0);
        wait_result(cyc);
        n_checks++;
        if (cyc !== 8 || sum !== 8'h03 || cout !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_add: cyc=%0d sum=%h cout=%b ovf=%b, want 8 03 0 0", cyc, sum, cout, ovf);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_chunk4();
        int cyc;
        a4        = 8'h7F;
        b4        = 8'h01;
        cin4      = 1'b0;
        in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        cyc = 0;
        while (out_valid4 !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc !== 2) begin
            n_fail++;
            $display("FAIL chunk4_latency: got %0d cycles, want 2", cyc);
        end
        n_checks++;
        if (sum4 !== 8'h80 || cout4 !== 1'b0 || ovf4 !== 1'b1) begin
            n_fail++;
            $display("FAIL chunk4_result: sum=%h cout=%b ovf=%b, want 80 0 1", sum4, cout4, ovf4);
        end
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        n_checks++;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
            n_fail++;
            $display("FAIL chunk4_handshake: vld=%b rdy=%b, want 0 1", out_valid4, in_ready4);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_operand_change();
        test_early_ready();
        test_reset_midrun();
        test_chunk4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_adder
`default_nettype wire
